imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
// - Pipelined, parametrised RV immediate generator feeding the decode->execute boundary.
// - Accepts instr[31:7] plus an immediate-type code over a valid/ready handshake.
// - Returns the sign- or zero-extended immediate at DATAWIDTH (32 or 64) with fixed 2-cycle latency.
// - Adds a shift-amount format, illegal-code flagging and a saturating error counter.
// PARAMETERS
// - DATAWIDTH  32  output width; legal values 32 or 64 only (elaboration error otherwise)
// - ERRCNTW    8   width of the illegal-code counter
// PORTS
// - clk_i        in   1             clock, all flops on rising edge
// - rst_n_i      in   1             asynchronous, active-low reset
// - in_valid_i   in   1             input beat valid
// - in_ready_o   out  1             input beat accepted when in_valid_i && in_ready_o
// - ImmSrc_i     in   3             immediate type code, see BEHAVIOUR
// - Imm_i        in   [31:7]        instruction bits 31..7
// - out_valid_o  out  1             ImmExt_o/illegal_o valid
// - out_ready_i  in   1             consumer accepts when out_valid_o && out_ready_i
// - ImmExt_o     out  DATAWIDTH     extended immediate
// - illegal_o    out  1             beat carried an unsupported ImmSrc
// - ErrCnt_o     out  ERRCNTW       saturating count of illegal beats delivered
// BEHAVIOUR
// - Reset (async assert, sync release): both stage valids=0, out_valid_o=0, ImmExt_o=0, illegal_o=0, ErrCnt_o=0.
// - Stage 1 registers ImmSrc_i/Imm_i. Stage 2 registers the extended result.
// - Accept at edge N -> out_valid_o high from edge N+2 when there is no stall.
// - Advance rules:
//   - adv2 = !v2 || out_ready_i
//   - adv1 = !v1 || adv2
//   - in_ready_o = adv1, combinational from out_ready_i; no other comb in->out path.
// - Hold rule: while out_valid_o && !out_ready_i, ImmExt_o/illegal_o/out_valid_o stay stable.
// - Throughput: one beat per cycle at full rate. No beat is dropped or duplicated under any ready pattern.
// - Encodings. "sx" = sign-extend from instr[31] to DATAWIDTH:
//   - 000 I: sx(instr[31:20])
//   - 001 S: sx({instr[31:25],instr[11:7]})
//   - 010 B: sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//   - 011 U: sx({instr[31:12],12'b0}); for DATAWIDTH=64, bits 63:32 = instr[31]
//   - 100 J: sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//   - 101 SH: zero-ext instr[25:20] if DATAWIDTH=64, instr[24:20] if 32
//   - 110 Z: see CONFIGURATION
//   - 111 and disabled codes: illegal, ImmExt_o=0, illegal_o=1
// - ErrCnt_o increments once per illegal beat at its output handshake, saturating at all-ones.
//   - It does not increment while the beat is held stalled.
// - Reset mid-operation clears in-flight beats; they are never delivered.
// CONFIGURATION
// - Macro IMM_ZIMM_EN.
// - Defined: code 110 = CSR zimm, ImmExt_o = zero-ext instr[19:15], illegal_o=0.
// - Undefined: code 110 is illegal (ImmExt_o=0, illegal_o=1, counted).
// TESTING
// - I: instr 0xFFF00093, ImmSrc 000, out_ready=1
//   -> 2 cycles later ImmExt_o=0xFFFFFFFF (0xFFFF_FFFF_FFFF_FFFF at 64).
// - B/U/J back-to-back, one per cycle:
//   - 0xFE000EE3 (010) -> 0xFFFFFFFC
//   - 0x123450B7 (011) -> 0x12345000
//   - 0xFF9FF06F (100) -> 0xFFFFFFF8
//   - Outputs arrive on 3 consecutive cycles.
// - Backpressure: stream 4 I-beats with out_ready_i toggling 1,0,0,1,...
//   -> in_ready_o=0 after 2 beats buffered; all 4 delivered in order; output stable while stalled.
// - Illegal: code 111 x3 with ERRCNTW=2
//   -> ImmExt_o=0, illegal_o=1 each beat; ErrCnt_o 1,2,3; a 4th illegal beat keeps ErrCnt_o=3.
// - Reset: drop rst_n_i with 2 beats in flight
//   -> out_valid_o=0 immediately, ErrCnt_o=0, no beat delivered after release.
// - Macro: instr 0x340FD073, code 110 -> with IMM_ZIMM_EN ImmExt_o=0x1F, illegal_o=0;
//   without it ImmExt_o=0, illegal_o=1.

Source files
------------

// File: rtl/imm_extend_if.sv
// -----------------------------------------------------------------------------
// imm_extend_if
// Handshake and data bundle between a decode-side producer, the immediate
// generator and an execute-side consumer. Signal names are kept from the
// generator's point of view (_i = into the generator, _o = out of it).
//
// Parameters
//   DATAWIDTH  width of the extended immediate (32 or 64)
//   ERRCNTW    width of the illegal-code counter
//
// Signals
//   in_valid_i   producer beat valid
//   in_ready_o   generator can take a beat
//   ImmSrc_i     immediate type code
//   Imm_i        instruction bits 31..7
//   out_valid_o  ImmExt_o / illegal_o valid
//   out_ready_i  consumer accepts the output beat
//   ImmExt_o     extended immediate
//   illegal_o    beat carried an unsupported type code
//   ErrCnt_o     saturating count of delivered illegal beats
//
// Modports
//   master  producer/consumer side (testbench, decode/execute glue)
//   slave   generator side
// -----------------------------------------------------------------------------
interface imm_extend_if #(
  parameter int DATAWIDTH = 32,
  parameter int ERRCNTW   = 8
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [2:0]           ImmSrc_i;
  logic [31:7]          Imm_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DATAWIDTH-1:0] ImmExt_o;
  logic                 illegal_o;
  logic [ERRCNTW-1:0]   ErrCnt_o;

  modport master (
    output in_valid_i, ImmSrc_i, Imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, ImmExt_o, illegal_o, ErrCnt_o
  );

  modport slave (
    input  in_valid_i, ImmSrc_i, Imm_i, out_ready_i,
    output in_ready_o, out_valid_o, ImmExt_o, illegal_o, ErrCnt_o
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Two-stage pipelined RISC-V immediate generator sitting on the
// decode->execute boundary. Stage 1 captures the type code and instruction
// bits, stage 2 holds the extended immediate. Both stages advance under a
// valid/ready handshake, so a full-rate stream moves one beat per cycle and a
// stalled consumer backs the pipe up without losing or repeating beats.
//
// Parameters
//   DATAWIDTH  32 or 64 (anything else stops elaboration)
//   ERRCNTW    width of the saturating illegal-beat counter
//
// Ports
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      imm_extend_if.slave: input handshake (in_valid_i/in_ready_o,
//            ImmSrc_i, Imm_i), output handshake (out_valid_o/out_ready_i,
//            ImmExt_o, illegal_o) and ErrCnt_o
//
// Type codes: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shift amount,
//             110 CSR zimm (only with IMM_ZIMM_EN), 111 illegal.
//
// Build option
//   IMM_ZIMM_EN  when defined, code 110 returns zero-extended instr[19:15];
//                otherwise code 110 is reported illegal and counted.
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int DATAWIDTH = 32,
  parameter int ERRCNTW   = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  imm_extend_if.slave  bus
);

  localparam int DW = DATAWIDTH;

  generate
    if ((DATAWIDTH != 32) && (DATAWIDTH != 64)) begin : g_bad_width
      $error("imm_extend_pipe: DATAWIDTH must be 32 or 64");
    end
    if (ERRCNTW < 1) begin : g_bad_cntw
      $error("imm_extend_pipe: ERRCNTW must be at least 1");
    end
  endgenerate

  // Stage 1 state
  logic          v1_q,   v1_d;
  logic [2:0]    src1_q, src1_d;
  logic [31:7]   imm1_q, imm1_d;
  // Stage 2 state
  logic          v2_q,   v2_d;
  logic [DW-1:0] ext2_q, ext2_d;
  logic          ill2_q, ill2_d;
  // Illegal-beat counter
  logic [ERRCNTW-1:0] cnt_q, cnt_d;

  logic          adv1_s;
  logic          adv2_s;
  logic [DW-1:0] ext_s;
  logic          ill_s;
  logic [DW-1:0] u_pre_s;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv2_s = !v2_q || bus.out_ready_i;
    adv1_s = !v1_q || adv2_s;
  end

  assign bus.in_ready_o = adv1_s;

  // U-type: sign-extend the 20-bit upper field first, then shift it into place
  // so the same expression works for 32 and 64 bits without a zero-width fill.
  assign u_pre_s = {{(DW-20){imm1_q[31]}}, imm1_q[31:12]} << 12;

  // Immediate decode of the stage-1 beat.
  always_comb begin
    ext_s = {DW{1'b0}};
    ill_s = 1'b0;
    case (src1_q)
      3'b000: ext_s = {{(DW-12){imm1_q[31]}}, imm1_q[31:20]};
      3'b001: ext_s = {{(DW-12){imm1_q[31]}}, imm1_q[31:25], imm1_q[11:7]};
      3'b010: ext_s = {{(DW-13){imm1_q[31]}}, imm1_q[31], imm1_q[7],
                       imm1_q[30:25], imm1_q[11:8], 1'b0};
      3'b011: ext_s = u_pre_s;
      3'b100: ext_s = {{(DW-21){imm1_q[31]}}, imm1_q[31], imm1_q[19:12],
                       imm1_q[20], imm1_q[30:21], 1'b0};
      3'b101: begin
        // Shift amount: 6 bits for RV64, 5 bits for RV32.
        if (DW == 64) begin
          ext_s = {{(DW-6){1'b0}}, imm1_q[25:20]};
        end else begin
          ext_s = {{(DW-5){1'b0}}, imm1_q[24:20]};
        end
      end
      3'b110: begin
`ifdef IMM_ZIMM_EN
        ext_s = {{(DW-5){1'b0}}, imm1_q[19:15]};
        ill_s = 1'b0;
`else
        ext_s = {DW{1'b0}};
        ill_s = 1'b1;
`endif
      end
      default: begin
        ext_s = {DW{1'b0}};
        ill_s = 1'b1;
      end
    endcase
  end

  // Stage 1 next state: load a new beat whenever the stage advances.
  always_comb begin
    v1_d   = v1_q;
    src1_d = src1_q;
    imm1_d = imm1_q;
    if (adv1_s) begin
      v1_d = bus.in_valid_i;
      if (bus.in_valid_i) begin
        src1_d = bus.ImmSrc_i;
        imm1_d = bus.Imm_i;
      end else begin
        src1_d = src1_q;
        imm1_d = imm1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 next state and the illegal counter, which only counts beats that
  // actually complete the output handshake.
  always_comb begin
    v2_d   = v2_q;
    ext2_d = ext2_q;
    ill2_d = ill2_q;
    cnt_d  = cnt_q;
    if (adv2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        ext2_d = ext_s;
        ill2_d = ill_s;
      end else begin
        ext2_d = ext2_q;
        ill2_d = ill2_q;
      end
    end else begin
      v2_d = v2_q;
    end
    if (v2_q && bus.out_ready_i && ill2_q && (cnt_q != {ERRCNTW{1'b1}})) begin
      cnt_d = cnt_q + ERRCNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // All pipeline and counter flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q   <= 1'b0;
      src1_q <= 3'b000;
      imm1_q <= 25'd0;
      v2_q   <= 1'b0;
      ext2_q <= {DW{1'b0}};
      ill2_q <= 1'b0;
      cnt_q  <= {ERRCNTW{1'b0}};
    end else begin
      v1_q   <= v1_d;
      src1_q <= src1_d;
      imm1_q <= imm1_d;
      v2_q   <= v2_d;
      ext2_q <= ext2_d;
      ill2_q <= ill2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out_valid_o = v2_q;
  assign bus.ImmExt_o    = ext2_q;
  assign bus.illegal_o   = ill2_q;
  assign bus.ErrCnt_o    = cnt_q;

endmodule
